// File: rtl/gcd_pkg.sv
// Shared types for the GCD control/datapath pair: FSM state encoding and
// mux select values seen on the control/status interface.
package gcd_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_CALC   = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    localparam logic SEL_A   = 1'b0;
    localparam logic SEL_B   = 1'b1;
    localparam logic SEL_EXT = 1'b0;
    localparam logic SEL_SUB = 1'b1;

endpackage

// File: rtl/gcd_ctrl.sv
// Control unit for the subtract-and-compare GCD datapath: loads two operands
// serially, then subtracts the smaller from the larger until both are equal.
module gcd_ctrl
    import gcd_pkg::*;
#(
    parameter int          CNT_W    = 16,
    parameter int unsigned MAX_ITER = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             lt,
    input  logic             gt,
    input  logic             eq,
    input  logic             a_zero,
    input  logic             b_zero,
    output logic             ld_a,
    output logic             ld_b,
    output logic             sel1,
    output logic             sel2,
    output logic             sel_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter_cnt
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

    state_t state;
    state_t next_state;
    logic   cnt_inc;
    logic   flags_ok;

    assign flags_ok = $onehot({lt, gt, eq});

    // Load/select decode: plain state decode in LOAD_*, flag-driven in CALC.
    always_comb begin
        next_state = state;
        cnt_inc    = 1'b0;
        ld_a       = 1'b0;
        ld_b       = 1'b0;
        sel1       = SEL_A;
        sel2       = SEL_A;
        sel_in     = SEL_EXT;
        case (state)
            S_IDLE: begin
                if (start) next_state = S_LOAD_A;
            end
            S_LOAD_A: begin
                ld_a       = 1'b1;
                sel_in     = SEL_EXT;
                next_state = S_LOAD_B;
            end
            S_LOAD_B: begin
                ld_b       = 1'b1;
                sel_in     = SEL_EXT;
                next_state = S_CALC;
            end
            S_CALC: begin
                if (a_zero || b_zero) begin
                    next_state = S_ERROR;
                end else if (!flags_ok) begin
                    next_state = S_ERROR;
                end else if (iter_cnt == MAX_CNT) begin
                    next_state = S_ERROR;
                end else if (eq) begin
                    next_state = S_DONE;
                end else if (gt) begin
                    ld_a    = 1'b1;
                    sel1    = SEL_A;
                    sel2    = SEL_B;
                    sel_in  = SEL_SUB;
                    cnt_inc = 1'b1;
                end else begin
                    ld_b    = 1'b1;
                    sel1    = SEL_B;
                    sel2    = SEL_A;
                    sel_in  = SEL_SUB;
                    cnt_inc = 1'b1;
                end
            end
            S_DONE:  next_state = S_IDLE;
            S_ERROR: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they match the
    // state they describe without any path from start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            iter_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != S_IDLE);
            done  <= (next_state == S_DONE) || (next_state == S_ERROR);
            err   <= (next_state == S_ERROR);
            if (state == S_IDLE && start) begin
                iter_cnt <= '0;
            end else if (cnt_inc && iter_cnt != '1) begin
                iter_cnt <= iter_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gcd_ctrl.sv
// Bench for gcd_ctrl: a small A/B register datapath closes the loop, and a
// Euclid-based reference predicts subtract count, result and error.
module tb_gcd_ctrl;

    localparam int MAXI = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        lt, gt, eq, a_zero, b_zero;
    logic        ld_a, ld_b, sel1, sel2, sel_in, busy, done, err;
    logic [15:0] iter_cnt;

    logic [7:0]  a_reg = 8'd0;
    logic [7:0]  b_reg = 8'd0;
    logic [7:0]  data_in = 8'd0;
    logic [7:0]  sub;
    logic        force_bad = 1'b0;

    int errors = 0;
    int checks = 0;

    gcd_ctrl #(.CNT_W(16), .MAX_ITER(MAXI)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .lt(lt), .gt(gt), .eq(eq), .a_zero(a_zero), .b_zero(b_zero),
        .ld_a(ld_a), .ld_b(ld_b), .sel1(sel1), .sel2(sel2), .sel_in(sel_in),
        .busy(busy), .done(done), .err(err), .iter_cnt(iter_cnt)
    );

    always #5 clk = ~clk;

    assign sub    = (sel1 ? b_reg : a_reg) - (sel2 ? b_reg : a_reg);
    assign lt     = (a_reg < b_reg) | force_bad;
    assign gt     = (a_reg > b_reg) | force_bad;
    assign eq     = (a_reg == b_reg) & ~force_bad;
    assign a_zero = (a_reg == 8'd0);
    assign b_zero = (b_reg == 8'd0);

    always @(posedge clk) begin
        if (ld_a) a_reg <= sel_in ? sub : data_in;
        if (ld_b) b_reg <= sel_in ? sub : data_in;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (ld_a && ld_b) begin
                errors++;
                $display("FAIL ld_overlap: ld_a=%0b ld_b=%0b, required not both 1", ld_a, ld_b);
            end
            checks++;
            if (!ld_a && !ld_b && (sel1 || sel2 || sel_in)) begin
                errors++;
                $display("FAIL sel_idle: sel1=%0b sel2=%0b sel_in=%0b, required 0 with no load",
                         sel1, sel2, sel_in);
            end
        end
    end

    // Subtract count is the sum of Euclid quotients minus the final step.
    function automatic void ref_job(input int a, input int b,
                                    output int n, output int g, output bit e);
        int x, y, t, cnt;
        x = a; y = b; cnt = 0;
        if (a == 0 || b == 0) begin
            n = 0; g = 0; e = 1'b1;
            return;
        end
        while (y != 0) begin
            cnt += x / y;
            t = x % y;
            x = y;
            y = t;
        end
        cnt -= 1;
        g = x;
        if (cnt >= MAXI) begin
            n = MAXI; e = 1'b1;
        end else begin
            n = cnt; e = 1'b0;
        end
    endfunction

    task automatic run_job(input int a, input int b, input bit hold, input int pulse_c,
                           output int dc, output int res, output bit e,
                           output int it, output int nl, output bit to);
        int c;
        nl = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        c = 1;
        start = hold;
        data_in = 8'(a);
        while (!done && c < 100) begin
            @(negedge clk);
            c++;
            if (c == 2) data_in = 8'(b);
            start = hold || (c == pulse_c);
            if (c >= 3 && !done && (ld_a || ld_b)) nl++;
        end
        dc  = c;
        to  = !done;
        res = int'(a_reg);
        e   = err;
        it  = int'(iter_cnt);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({ld_a, ld_b, sel1, sel2, sel_in, busy, done, err} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 00000000",
                     {ld_a, ld_b, sel1, sel2, sel_in, busy, done, err});
        end
        checks++;
        if (iter_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_iter: got %0d, required 0", iter_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %0b, required 0", busy);
        end
    endtask

    task automatic test_directed(input string nm, input int a, input int b, input int pulse_c,
                                 input int exp_dc, input int exp_res, input bit exp_err,
                                 input int exp_it, input int exp_nl);
        int dc, res, it, nl;
        bit e, to;
        run_job(a, b, 1'b0, pulse_c, dc, res, e, it, nl, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL %s_timeout: no done within bound", nm);
        end
        checks++;
        if (dc != exp_dc) begin
            errors++;
            $display("FAIL %s_done_cycle: got k+%0d, required k+%0d", nm, dc, exp_dc);
        end
        checks++;
        if (e !== exp_err) begin
            errors++;
            $display("FAIL %s_err: got %0b, required %0b", nm, e, exp_err);
        end
        checks++;
        if (it != exp_it) begin
            errors++;
            $display("FAIL %s_iter: got %0d, required %0d", nm, it, exp_it);
        end
        checks++;
        if (nl != exp_nl) begin
            errors++;
            $display("FAIL %s_calc_loads: got %0d, required %0d", nm, nl, exp_nl);
        end
        if (exp_res >= 0) begin
            checks++;
            if (res != exp_res) begin
                errors++;
                $display("FAIL %s_result: got %0d, required %0d", nm, res, exp_res);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_return_idle: busy=%0b done=%0b, required 0 0", nm, busy, done);
        end
    endtask

    task automatic test_timeout();
        test_directed("timeout", 1, 100, 0, 4 + MAXI, 1, 1'b1, MAXI, MAXI);
        checks++;
        if (b_reg !== 8'd92) begin
            errors++;
            $display("FAIL timeout_b_reg: got %0d, required 92", b_reg);
        end
    endtask

    task automatic test_reset_mid_calc();
        bit seen_done;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; data_in = 8'd1;
        @(negedge clk); data_in = 8'd100;
        repeat (3) @(negedge clk);
        checks++;
        if (ld_b !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midcalc_active: ld_b=%0b busy=%0b, required 1 1", ld_b, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ld_a, ld_b, sel1, sel2, sel_in, busy, done, err} !== 8'b0 || iter_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midcalc_reset: outs=%b iter=%0d, required 00000000 0",
                     {ld_a, ld_b, sel1, sel2, sel_in, busy, done, err}, iter_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin
            errors++;
            $display("FAIL midcalc_no_done: got activity after reset, required none");
        end
    endtask

    task automatic test_flag_fault();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; data_in = 8'd48;
        @(negedge clk); data_in = 8'd18;
        @(negedge clk);
        force_bad = 1'b1;
        #1;
        checks++;
        if (ld_a !== 1'b0 || ld_b !== 1'b0) begin
            errors++;
            $display("FAIL fault_loads: ld_a=%0b ld_b=%0b, required 0 0", ld_a, ld_b);
        end
        @(negedge clk);
        force_bad = 1'b0;
        checks++;
        if (done !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL fault_err: done=%0b err=%0b, required 1 1", done, err);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int dc, res, it, nl, c;
        bit e, to;
        run_job(7, 7, 1'b1, 0, dc, res, e, it, nl, to);
        checks++;
        if (to || dc != 4 || e !== 1'b0 || res != 7) begin
            errors++;
            $display("FAIL b2b_first: to=%0b dc=%0d err=%0b res=%0d, required 0 4 0 7", to, dc, e, res);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%0b, required 0", busy);
        end
        @(negedge clk);
        checks++;
        if (ld_a !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: ld_a=%0b busy=%0b, required 1 1", ld_a, busy);
        end
        start = 1'b0;
        data_in = 8'd5;
        @(negedge clk);
        data_in = 8'd9;
        c = 0;
        while (!done && c < 100) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (!done || err !== 1'b0 || a_reg !== 8'd1 || iter_cnt !== 16'd5) begin
            errors++;
            $display("FAIL b2b_second: done=%0b err=%0b a=%0d iter=%0d, required 1 0 1 5",
                     done, err, a_reg, iter_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int a, b, dc, res, it, nl, en, eg;
        bit e, to, ee;
        for (int i = 0; i < 12; i++) begin
            a = int'($urandom_range(0, 40));
            b = int'($urandom_range(0, 40));
            ref_job(a, b, en, eg, ee);
            run_job(a, b, 1'b0, 0, dc, res, e, it, nl, to);
            checks++;
            if (to || dc != 4 + en || e !== ee || it != en || (!ee && res != eg)) begin
                errors++;
                $display("FAIL rand_%0d_%0d: to=%0b dc=%0d err=%0b iter=%0d res=%0d, required 0 %0d %0b %0d %0d",
                         a, b, to, dc, e, it, res, 4 + en, ee, en, eg);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed("g48_18", 48, 18, 0, 8, 6, 1'b0, 4, 4);
        test_directed("eq7", 7, 7, 0, 4, 7, 1'b0, 0, 0);
        test_directed("zero_a", 0, 5, 0, 4, -1, 1'b1, 0, 0);
        test_timeout();
        test_directed("start_ign", 48, 18, 5, 8, 6, 1'b0, 4, 4);
        test_reset_mid_calc();
        test_flag_fault();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
